mem_port_arbiter: RTL

//  Shares the single BRAM port between two requesters: port 0 (instruction fetch) and port 1 (data/mem stage).

---
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single BRAM port: fetch (port 0) and data (port 1).
// Grants at most one request per cycle and routes each response back to the port that issued it.
module mem_port_arbiter #(
    parameter int MEM_WIDTH    = 15,
    parameter int READ_LATENCY = 1,
    parameter int FIXED_PRIO   = 0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [1:0]           rq_valid,
    output logic [1:0]           rq_ready,
    input  logic [31:0]          rq_addr0,
    input  logic [31:0]          rq_addr1,
    input  logic [3:0]           rq_we0,
    input  logic [3:0]           rq_we1,
    input  logic [31:0]          rq_wdata0,
    input  logic [31:0]          rq_wdata1,
    output logic [1:0]           rs_valid,
    output logic [31:0]          rs_rdata0,
    output logic [31:0]          rs_rdata1,
    output logic                 ram_clka,
    output logic                 ram_rsta,
    output logic                 ram_ena,
    output logic [3:0]           ram_wea,
    output logic [MEM_WIDTH-1:0] ram_addr,
    output logic [31:0]          ram_dina,
    input  logic [31:0]          ram_douta
);

    logic [1:0]              w_gnt;
    logic                    w_sel;
    logic [3:0]              w_we;
    logic                    w_out_vld;
    logic                    r_last_gnt;
    logic [READ_LATENCY-1:0] r_vld;
    logic [READ_LATENCY-1:0] r_port;
    logic [READ_LATENCY-1:0] r_wr;
    logic                    w_unused_bits;

    // Byte offset and bits above the BRAM range are ignored by design.
    assign w_unused_bits = ^{rq_addr0[31:MEM_WIDTH+2], rq_addr0[1:0],
                             rq_addr1[31:MEM_WIDTH+2], rq_addr1[1:0]};

    always_comb begin
        w_gnt = 2'b00;
        if (rstn) begin
            case (rq_valid)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11: begin
                    if (FIXED_PRIO != 0)
                        w_gnt = 2'b10;
                    else
                        w_gnt = r_last_gnt ? 2'b01 : 2'b10;
                end
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign rq_ready = w_gnt;
    assign w_sel    = w_gnt[1];
    assign w_we     = w_sel ? rq_we1 : rq_we0;

    assign ram_clka = clk;
    assign ram_rsta = ~rstn;
    assign ram_ena  = |w_gnt;
    assign ram_wea  = ram_ena ? w_we : 4'b0000;
    assign ram_addr = w_sel ? rq_addr1[MEM_WIDTH+1:2] : rq_addr0[MEM_WIDTH+1:2];
    assign ram_dina = w_sel ? rq_wdata1 : rq_wdata0;

    // Pointer holds the most recently granted port; reset value lets port 0 win the first tie.
    always_ff @(posedge clk) begin
        if (!rstn)
            r_last_gnt <= 1'b1;
        else if (|w_gnt)
            r_last_gnt <= w_gnt[1];
    end

    // Response tag pipeline, one stage per cycle of BRAM read latency.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_vld  <= '0;
            r_port <= '0;
            r_wr   <= '0;
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                r_vld[i]  <= r_vld[i-1];
                r_port[i] <= r_port[i-1];
                r_wr[i]   <= r_wr[i-1];
            end
            r_vld[0]  <= |w_gnt;
            r_port[0] <= w_gnt[1];
            r_wr[0]   <= |w_we;
        end
    end

    assign w_out_vld   = r_vld[READ_LATENCY-1] && rstn;
    assign rs_valid[0] = w_out_vld && !r_port[READ_LATENCY-1];
    assign rs_valid[1] = w_out_vld &&  r_port[READ_LATENCY-1];
    assign rs_rdata0   = (rs_valid[0] && !r_wr[READ_LATENCY-1]) ? ram_douta : 32'h0;
    assign rs_rdata1   = (rs_valid[1] && !r_wr[READ_LATENCY-1]) ? ram_douta : 32'h0;

endmodule
